// File: rtl/tamagotchi_pkg.sv
// Shared Tamagotchi types: pet state codes, frame geometry, sequencer FSM encoding.
// No ports; imported by the display sequencer, its byte mux and its stream interface.
package tamagotchi_pkg;

    localparam int ESTADO_W = 4;
    localparam int N_BYTES  = 1024;
    localparam int BYTE_W   = 8;
    localparam int IDX_W    = 10;

    localparam logic [ESTADO_W-1:0] IDLE       = 4'd0;
    localparam logic [ESTADO_W-1:0] DORMINDO   = 4'd1;
    localparam logic [ESTADO_W-1:0] COMENDO    = 4'd2;
    localparam logic [ESTADO_W-1:0] DANDO_AULA = 4'd3;
    localparam logic [ESTADO_W-1:0] MORTO      = 4'd4;

    typedef logic [1:0] seq_estado_t;

    localparam seq_estado_t OCIOSO    = 2'd0;
    localparam seq_estado_t SELECIONA = 2'd1;
    localparam seq_estado_t TRANSMITE = 2'd2;
    localparam seq_estado_t FIM       = 2'd3;

endpackage

// File: rtl/sequenciador_display_if.sv
// Byte stream toward the OLED serializer with valid/ready handshake.
// Signals: byte_dado, byte_valido (master out), byte_pronto (slave out).
interface sequenciador_display_if;
    import tamagotchi_pkg::*;

    logic [BYTE_W-1:0] byte_dado;
    logic              byte_valido;
    logic              byte_pronto;

    modport master (
        output byte_dado,
        output byte_valido,
        input  byte_pronto
    );

    modport slave (
        input  byte_dado,
        input  byte_valido,
        output byte_pronto
    );

endinterface

// File: rtl/sequenciador_display_seletor_byte.sv
// Combinational 1024:1 byte mux over the frame image.
// Ports: imagem (frame, byte i at [i*8+7:i*8]), index (byte number), byte_o.
module seletor_byte
    import tamagotchi_pkg::*;
(
    input  logic [N_BYTES*BYTE_W-1:0] imagem,
    input  logic [IDX_W-1:0]          index,
    output logic [BYTE_W-1:0]         byte_o
);

    assign byte_o = imagem[index*BYTE_W +: BYTE_W];

endmodule

// File: rtl/sequenciador_display.sv
// Frame sequencer: latches the pet state for the image controller on a frame
// tick, then streams the 1024-byte image, byte 0 first, over a valid/ready link.
// Ports: clk, rst (async, active high), estado, tick_quadro, imagem,
//        estado_img, saida (byte stream master), ocupado, quadro_fim.
// Macro REFRESH_ON_CHANGE_EN: idle ticks only refresh when estado changed
// (the first tick after reset always refreshes).
module sequenciador_display
    import tamagotchi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ESTADO_W-1:0]       estado,
    input  logic                      tick_quadro,
    input  logic [N_BYTES*BYTE_W-1:0] imagem,
    output logic [ESTADO_W-1:0]       estado_img,
    sequenciador_display_if.master    saida,
    output logic                      ocupado,
    output logic                      quadro_fim
);

    seq_estado_t         fsm_q, fsm_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                pendente_q, pendente_d;
    logic [ESTADO_W-1:0] estado_img_q, estado_img_d;
    logic [BYTE_W-1:0]   byte_dado_q, byte_dado_d;
    logic                valido_q, valido_d;

    logic                fire;
    logic                ultimo;
    logic                inicia;
    logic [IDX_W-1:0]    sel_idx;
    logic [BYTE_W-1:0]   byte_sel;

`ifdef REFRESH_ON_CHANGE_EN
    logic                primeira_q, primeira_d;
`endif

    // Mux looks one byte ahead on a transfer so the next byte lands
    // on the same edge that accepts the current one.
    seletor_byte u_seletor (
        .imagem (imagem),
        .index  (sel_idx),
        .byte_o (byte_sel)
    );

    assign fire    = valido_q & saida.byte_pronto;
    assign ultimo  = (index_q == IDX_W'(N_BYTES - 1));
    assign sel_idx = fire ? index_q + IDX_W'(1) : index_q;

`ifdef REFRESH_ON_CHANGE_EN
    assign inicia = pendente_q |
                    (tick_quadro &
                     (primeira_q | (estado != estado_img_q)));
`else
    assign inicia = pendente_q | tick_quadro;
`endif

    always_comb begin
        fsm_d        = fsm_q;
        index_d      = index_q;
        pendente_d   = pendente_q;
        estado_img_d = estado_img_q;
        byte_dado_d  = byte_dado_q;
        valido_d     = valido_q;
`ifdef REFRESH_ON_CHANGE_EN
        primeira_d   = primeira_q;
`endif
        // One-deep request memory for ticks arriving while busy,
        // including the FIM cycle.
        if (tick_quadro && fsm_q != OCIOSO) begin
            pendente_d = 1'b1;
        end
        unique case (fsm_q)
            OCIOSO: begin
                if (inicia) begin
                    fsm_d      = SELECIONA;
                    pendente_d = 1'b0;
`ifdef REFRESH_ON_CHANGE_EN
                    primeira_d = 1'b0;
`endif
                end
            end
            SELECIONA: begin
                estado_img_d = estado;
                index_d      = '0;
                fsm_d        = TRANSMITE;
            end
            TRANSMITE: begin
                // First TRANSMITE cycle only loads byte 0, giving the
                // image controller one cycle to follow estado_img.
                if (!valido_q) begin
                    valido_d    = 1'b1;
                    byte_dado_d = byte_sel;
                end else if (fire) begin
                    if (ultimo) begin
                        valido_d = 1'b0;
                        fsm_d    = FIM;
                    end else begin
                        index_d     = sel_idx;
                        byte_dado_d = byte_sel;
                    end
                end
            end
            FIM: begin
                fsm_d = OCIOSO;
            end
            default: begin
                fsm_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= OCIOSO;
            index_q      <= '0;
            pendente_q   <= 1'b0;
            estado_img_q <= IDLE;
            byte_dado_q  <= '0;
            valido_q     <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            index_q      <= index_d;
            pendente_q   <= pendente_d;
            estado_img_q <= estado_img_d;
            byte_dado_q  <= byte_dado_d;
            valido_q     <= valido_d;
        end
    end

`ifdef REFRESH_ON_CHANGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primeira_q <= 1'b1;
        end else begin
            primeira_q <= primeira_d;
        end
    end
`endif

    assign estado_img        = estado_img_q;
    assign saida.byte_dado   = byte_dado_q;
    assign saida.byte_valido = valido_q;
    assign ocupado           = (fsm_q != OCIOSO);
    assign quadro_fim        = (fsm_q == FIM);

endmodule

// File: tb/tb_sequenciador_display.sv
// Directed bench for sequenciador_display: byte scoreboard, latency,
// backpressure, mid-frame state change, pending ticks, async reset.
module tb_sequenciador_display;
    import tamagotchi_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [ESTADO_W-1:0]       estado;
    logic                      tick_quadro;
    logic [N_BYTES*BYTE_W-1:0] imagem;
    logic [ESTADO_W-1:0]       estado_img;
    logic                      ocupado;
    logic                      quadro_fim;

    sequenciador_display_if bus ();

    sequenciador_display dut (
        .clk         (clk),
        .rst         (rst),
        .estado      (estado),
        .tick_quadro (tick_quadro),
        .imagem      (imagem),
        .estado_img  (estado_img),
        .saida       (bus),
        .ocupado     (ocupado),
        .quadro_fim  (quadro_fim)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         nfire = 0;
    bit         toggle_pr = 1'b0;
    logic [7:0] sb[$];

    function automatic logic [7:0] pat(logic [3:0] s, int i);
        return 8'((i * 13) + ((i >> 8) * 5) + (int'(s) * 37) + 1);
    endfunction

    // Image controller model: image depends on the registered select.
    always_comb begin
        imagem = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            imagem[i*8 +: 8] = pat(estado_img, i);
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(logic [3:0] s);
        for (int i = 0; i < N_BYTES; i++) sb.push_back(pat(s, i));
    endtask

    // One clock: checks a transfer on the coming edge against the
    // scoreboard, then checks hold-stability if it stalled.
    task automatic step();
        logic       fire;
        logic       hold;
        logic [7:0] prev;
        if (toggle_pr) bus.byte_pronto = ~bus.byte_pronto;
        fire = bus.byte_valido & bus.byte_pronto;
        hold = bus.byte_valido & ~bus.byte_pronto;
        prev = bus.byte_dado;
        if (fire) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("byte", {24'd0, bus.byte_dado}, {24'd0, sb.pop_front()});
            nfire++;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_valid", {31'd0, bus.byte_valido}, 32'd1);
            chk("hold_data", {24'd0, bus.byte_dado}, {24'd0, prev});
        end
    endtask

    task automatic tick_step();
        tick_quadro = 1'b1;
        step();
        tick_quadro = 1'b0;
    endtask

    task automatic run_to_fim(int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!quadro_fim && n < budget);
        chk("fim_seen", {31'd0, quadro_fim}, 32'd1);
    endtask

    task automatic run_to_fires(int target, int budget);
        int n;
        n = 0;
        while (nfire < target && n < budget) begin
            step();
            n++;
        end
        chk("fire_count", nfire, target);
    endtask

    initial begin
        int n;
        int first_v;
        int vcnt;
        int fim_at;

        rst             = 1'b1;
        estado          = IDLE;
        tick_quadro     = 1'b0;
        bus.byte_pronto = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.byte_valido}, 32'd0);
        chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rst_fim", {31'd0, quadro_fim}, 32'd0);
        chk("rst_img", {28'd0, estado_img}, 32'd0);
        chk("rst_dado", {24'd0, bus.byte_dado}, 32'd0);
        rst = 1'b0;
        step();

        // Full frame, pronto high: latency and throughput.
        estado = COMENDO;
        push_frame(COMENDO);
        tick_step();
        chk("t0_ocupado", {31'd0, ocupado}, 32'd1);
        chk("t0_img", {28'd0, estado_img}, 32'd0);
        n = 0; first_v = -1; vcnt = 0; fim_at = -1;
        while (n < 1100 && fim_at < 0) begin
            step();
            n++;
            if (n == 1) begin
                chk("t1_img", {28'd0, estado_img}, 32'd2);
                chk("t1_valid", {31'd0, bus.byte_valido}, 32'd0);
            end
            if (bus.byte_valido) begin
                vcnt++;
                if (first_v < 0) first_v = n;
            end
            if (quadro_fim) fim_at = n;
        end
        chk("first_valid", first_v, 32'd2);
        chk("valid_cycles", vcnt, 32'd1024);
        chk("fim_cycle", fim_at, 32'd1026);
        chk("sb_empty1", sb.size(), 32'd0);
        step();
        chk("fim_pulse", {31'd0, quadro_fim}, 32'd0);
        chk("idle_after", {31'd0, ocupado}, 32'd0);

        // Backpressure: pronto toggles every cycle.
        estado = DORMINDO;
        push_frame(DORMINDO);
        nfire = 0;
        toggle_pr = 1'b1;
        tick_step();
        run_to_fim(3000);
        chk("bp_fires", nfire, 32'd1024);
        chk("sb_empty2", sb.size(), 32'd0);
        toggle_pr = 1'b0;
        bus.byte_pronto = 1'b1;
        step();

        // estado changes mid-frame; select stays frozen.
        estado = IDLE;
        push_frame(IDLE);
        nfire = 0;
        tick_step();
        run_to_fires(500, 1000);
        estado = MORTO;
        run_to_fim(1000);
        chk("frozen_img", {28'd0, estado_img}, 32'd0);
        chk("sb_empty3", sb.size(), 32'd0);
        step();
        push_frame(MORTO);
        tick_step();
        step();
        chk("next_img", {28'd0, estado_img}, 32'd4);
        run_to_fim(1100);
        chk("sb_empty4", sb.size(), 32'd0);
        step();

        // Three ticks during a frame: exactly one extra frame.
        estado = COMENDO;
        push_frame(COMENDO);
        tick_step();
        repeat (3) begin
            repeat (9) step();
            tick_step();
        end
        run_to_fim(1100);
        push_frame(COMENDO);
        step();
        step();
        chk("pend_start", {31'd0, ocupado}, 32'd1);
        run_to_fim(1100);
        chk("sb_empty5", sb.size(), 32'd0);
        repeat (5) begin
            step();
            chk("no_third", {31'd0, ocupado}, 32'd0);
        end

        // Async reset mid-frame, then a clean restart.
        estado = DANDO_AULA;
        push_frame(DANDO_AULA);
        nfire = 0;
        tick_step();
        run_to_fires(300, 600);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.byte_valido}, 32'd0);
        chk("arst_img", {28'd0, estado_img}, 32'd0);
        chk("arst_ocupado", {31'd0, ocupado}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            step();
            chk("arst_nofim", {31'd0, quadro_fim}, 32'd0);
        end
        push_frame(DANDO_AULA);
        tick_step();
        run_to_fim(1100);
        chk("sb_empty6", sb.size(), 32'd0);
        step();

        // Tick with unchanged estado, then with a new one.
`ifdef REFRESH_ON_CHANGE_EN
        tick_step();
        repeat (4) begin
            step();
            chk("no_refresh", {31'd0, ocupado}, 32'd0);
        end
`else
        push_frame(DANDO_AULA);
        tick_step();
        run_to_fim(1100);
        chk("sb_empty7", sb.size(), 32'd0);
        step();
`endif
        estado = DORMINDO;
        push_frame(DORMINDO);
        tick_step();
        run_to_fim(1100);
        chk("sb_empty8", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
